// File: rtl/stack_op_engine.sv
// rtl/stack_op_engine.sv - command sequencer and ALU for the 8-bit hardware stack
// DUP/SWAP are built only when STACK_ENGINE_DUP_SWAP_EN is defined.
module stack_op_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_imm,
  output logic                         stk_push,
  output logic                         stk_pop,
  output logic                         stk_tos,
  output logic [WIDTH-1:0]             stk_wdata,
  input  logic [WIDTH-1:0]             stk_rdata,
  output logic [WIDTH-1:0]             result,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_PEEK = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  typedef enum logic [2:0] {
    IDLE, ISSUE1, ISSUE2, CAPTURE, PUSH1, PUSH2, DONE, ERR
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic              has1;
  logic              has2;
  logic              not_full;
  logic              legal;
  logic [WIDTH-1:0]  alu_r;

  assign has1     = (count != '0);
  assign has2     = (count >= CW'(2));
  assign not_full = (count < CW'(DEPTH));

  // The stack itself never flags under/overflow, so occupancy is policed here.
  always_comb begin
    legal = 1'b0;
    case (cmd_op)
      OP_PUSH:                legal = not_full;
      OP_POP, OP_PEEK:        legal = has1;
      OP_ADD, OP_SUB, OP_AND: legal = has2;
`ifdef STACK_ENGINE_DUP_SWAP_EN
      OP_DUP:                 legal = has1 && not_full;
      OP_SWAP:                legal = has2;
`endif
      default:                legal = 1'b0;
    endcase
  end

  // y is the second pop arriving on stk_rdata; x (the old top) is already in x_q.
  always_comb begin
    alu_r = '0;
    case (op_q)
      OP_ADD:  alu_r = stk_rdata + x_q;
      OP_SUB:  alu_r = stk_rdata - x_q;
      default: alu_r = stk_rdata & x_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      stk_tos   <= 1'b0;
      stk_wdata <= '0;
      result    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
      op_q      <= OP_PUSH;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_tos  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            if (!legal) begin
              state <= ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  stk_push  <= 1'b1;
                  stk_wdata <= cmd_imm;
                  x_q       <= cmd_imm;
                  state     <= PUSH1;
                end
                OP_PEEK, OP_DUP: begin
                  stk_tos <= 1'b1;
                  state   <= ISSUE1;
                end
                default: begin
                  stk_pop <= 1'b1;
                  state   <= ISSUE1;
                end
              endcase
            end
          end
        end
        ISSUE1: begin
          if (op_q == OP_POP || op_q == OP_PEEK || op_q == OP_DUP) begin
            state <= CAPTURE;
          end else begin
            stk_pop <= 1'b1;
            state   <= ISSUE2;
          end
        end
        ISSUE2: begin
          x_q   <= stk_rdata;
          state <= CAPTURE;
        end
        CAPTURE: begin
          case (op_q)
            OP_POP, OP_PEEK: begin
              result <= stk_rdata;
              done   <= 1'b1;
              if (op_q == OP_POP) count <= count - CW'(1);
              state  <= DONE;
            end
            OP_DUP: begin
              x_q       <= stk_rdata;
              stk_push  <= 1'b1;
              stk_wdata <= stk_rdata;
              state     <= PUSH1;
            end
            OP_SWAP: begin
              y_q       <= stk_rdata;
              stk_push  <= 1'b1;
              stk_wdata <= x_q;
              state     <= PUSH1;
            end
            default: begin
              x_q       <= alu_r;
              stk_push  <= 1'b1;
              stk_wdata <= alu_r;
              state     <= PUSH1;
            end
          endcase
        end
        PUSH1: begin
          if (op_q == OP_SWAP) begin
            stk_push  <= 1'b1;
            stk_wdata <= y_q;
            state     <= PUSH2;
          end else begin
            result <= x_q;
            done   <= 1'b1;
            if (op_q == OP_PUSH || op_q == OP_DUP) count <= count + CW'(1);
            else                                   count <= count - CW'(1);
            state  <= DONE;
          end
        end
        PUSH2: begin
          result <= x_q;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE, ERR: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
